// File: rtl/elevator_pkg.sv
// Shared types, constants and helpers for the elevator scheduler.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 8;
  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned STATUS_W   = 4;

  // Display status codes
  localparam logic [STATUS_W-1:0] ST_OFF       = 4'd0;
  localparam logic [STATUS_W-1:0] ST_IDLE      = 4'd1;
  localparam logic [STATUS_W-1:0] ST_MOVE_UP   = 4'd2;
  localparam logic [STATUS_W-1:0] ST_MOVE_DOWN = 4'd3;
  localparam logic [STATUS_W-1:0] ST_OPEN_UP   = 4'd4;
  localparam logic [STATUS_W-1:0] ST_OPEN_DOWN = 4'd5;
  localparam logic [STATUS_W-1:0] ST_CLOSING   = 4'd6;
  localparam logic [STATUS_W-1:0] ST_EMERGENCY = 4'd7;

  // Hall buttons that physically cannot exist: no up at the top, no down at the bottom
  localparam logic [NUM_FLOORS-1:0] UP_MASK = 8'h7F;
  localparam logic [NUM_FLOORS-1:0] DN_MASK = 8'hFE;

  typedef enum logic [STATUS_W-1:0] {
    S_OFF       = ST_OFF,
    S_IDLE      = ST_IDLE,
    S_MOVE_UP   = ST_MOVE_UP,
    S_MOVE_DOWN = ST_MOVE_DOWN,
    S_OPEN_UP   = ST_OPEN_UP,
    S_OPEN_DOWN = ST_OPEN_DOWN,
    S_CLOSING   = ST_CLOSING,
    S_EMERGENCY = ST_EMERGENCY
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // One-hot select of a floor
  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  // Distance to the nearest request strictly above f (0 when none)
  function automatic logic [FLOOR_W-1:0] dist_above(input logic [NUM_FLOORS-1:0] v,
                                                    input logic [FLOOR_W-1:0]    f);
    logic [FLOOR_W-1:0] d;
    d = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (i > int'(f) && v[i]) d = FLOOR_W'(i - int'(f));
    end
    return d;
  endfunction

  // Distance to the nearest request strictly below f (0 when none)
  function automatic logic [FLOOR_W-1:0] dist_below(input logic [NUM_FLOORS-1:0] v,
                                                    input logic [FLOOR_W-1:0]    f);
    logic [FLOOR_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < int'(f) && v[i]) d = FLOOR_W'(int'(f) - i);
    end
    return d;
  endfunction

endpackage

// File: rtl/elevator_req_bank.sv
// Latched car / hall-up / hall-down requests with clear-wins priority and
// position reductions relative to a query floor.
module elevator_req_bank
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] floor_btn,
  input  logic [NUM_FLOORS-1:0] up,
  input  logic [NUM_FLOORS-1:0] down,
  input  logic                  clr_all,
  input  logic [NUM_FLOORS-1:0] clr_car,
  input  logic [NUM_FLOORS-1:0] clr_up,
  input  logic [NUM_FLOORS-1:0] clr_dn,
  input  logic [FLOOR_W-1:0]    qry_floor,
  output logic [NUM_FLOORS-1:0] car_req,
  output logic [NUM_FLOORS-1:0] up_req,
  output logic [NUM_FLOORS-1:0] down_req,
  output logic                  car_at_c,
  output logic                  up_at_c,
  output logic                  dn_at_c,
  output logic                  above_c,
  output logic                  below_c
);

  logic [NUM_FLOORS-1:0] car_q, car_d;
  logic [NUM_FLOORS-1:0] up_q,  up_d;
  logic [NUM_FLOORS-1:0] dn_q,  dn_d;
  logic [NUM_FLOORS-1:0] any_v;

  // Set on press, clear wins over a same-cycle press
  always_comb begin
    car_d = (car_q | floor_btn)      & ~clr_car;
    up_d  = (up_q  | (up & UP_MASK)) & ~clr_up;
    dn_d  = (dn_q  | (down & DN_MASK)) & ~clr_dn;
    if (clr_all) begin
      car_d = '0;
      up_d  = '0;
      dn_d  = '0;
    end
  end

  // Request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= car_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

  assign any_v    = car_q | up_q | dn_q;
  assign car_req  = car_q;
  assign up_req   = up_q;
  assign down_req = dn_q;
  assign car_at_c = car_q[qry_floor];
  assign up_at_c  = up_q[qry_floor];
  assign dn_at_c  = dn_q[qry_floor];

  // Any request strictly above / below the query floor
  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(qry_floor) && any_v[i]) above_c = 1'b1;
      if (i < int'(qry_floor) && any_v[i]) below_c = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) elevator controller: travel, door-open and door-close
// phases timed on a slow tick. Define DOOR_REOPEN_EN to let a press at the
// current floor reopen a closing door instead of queueing a new request.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_TICKS = 3,
  parameter int unsigned DOOR_TICKS   = 4,
  parameter int unsigned CLOSE_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       power,
  input  logic       emergency,
  input  logic [7:0] floor_btn,
  input  logic [7:0] up,
  input  logic [7:0] down,
  output logic [2:0] floor,
  output logic [2:0] countdown,
  output logic [3:0] status,
  output logic [7:0] car_req,
  output logic [7:0] up_req,
  output logic [7:0] down_req
);

  state_e             state_q, state_d;
  dir_e               dir_q,   dir_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic                  clr_all;
  logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;
  logic [FLOOR_W-1:0]    qry_floor_c;
  logic                  car_at_c, up_at_c, dn_at_c, above_c, below_c;
  logic [NUM_FLOORS-1:0] all_req_c;
  logic [FLOOR_W-1:0]    d_up_c, d_dn_c;
  logic                  press_c;
  logic                  cnt_one_c;

  logic                  open_c;
  dir_e                  open_dir;
  logic [FLOOR_W-1:0]    open_floor;

  elevator_req_bank u_req_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .floor_btn (floor_btn),
    .up        (up),
    .down      (down),
    .clr_all   (clr_all),
    .clr_car   (clr_car),
    .clr_up    (clr_up),
    .clr_dn    (clr_dn),
    .qry_floor (qry_floor_c),
    .car_req   (car_req),
    .up_req    (up_req),
    .down_req  (down_req),
    .car_at_c  (car_at_c),
    .up_at_c   (up_at_c),
    .dn_at_c   (dn_at_c),
    .above_c   (above_c),
    .below_c   (below_c)
  );

  // While moving, the stop decision looks at the floor being arrived at
  assign qry_floor_c = (state_q == S_MOVE_UP)   ? floor_q + FLOOR_W'(1) :
                       (state_q == S_MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q;

  assign all_req_c = car_req | up_req | down_req;
  assign d_up_c    = dist_above(all_req_c, floor_q);
  assign d_dn_c    = dist_below(all_req_c, floor_q);
  assign cnt_one_c = (cnt_q == CNT_W'(1));

  // Car button or served-direction hall button at the current floor
  always_comb begin
    press_c = floor_btn[floor_q];
    if (dir_q == DIR_UP) press_c = press_c | (up[floor_q] & UP_MASK[floor_q]);
    else                 press_c = press_c | (down[floor_q] & DN_MASK[floor_q]);
  end

  // Next-state, counter, floor, direction and request-clear logic
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    clr_all    = 1'b0;
    clr_car    = '0;
    clr_up     = '0;
    clr_dn     = '0;
    open_c     = 1'b0;
    open_dir   = dir_q;
    open_floor = floor_q;

    if (!power) begin
      state_d = S_OFF;
      cnt_d   = '0;
      clr_all = 1'b1;
    end else if (state_q == S_OFF) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      clr_all = 1'b1;
    end else if (emergency) begin
      state_d = S_EMERGENCY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (car_at_c || up_at_c || dn_at_c) begin
            open_c = 1'b1;
            if (up_at_c && (dir_q == DIR_UP || !dn_at_c)) open_dir = DIR_UP;
            else                                          open_dir = DIR_DOWN;
          end else if (above_c && (!below_c || d_up_c < d_dn_c ||
                                   (d_up_c == d_dn_c && dir_q == DIR_UP))) begin
            state_d = S_MOVE_UP;
            cnt_d   = CNT_W'(TRAVEL_TICKS);
            dir_d   = DIR_UP;
          end else if (below_c) begin
            state_d = S_MOVE_DOWN;
            cnt_d   = CNT_W'(TRAVEL_TICKS);
            dir_d   = DIR_DOWN;
          end
        end

        S_MOVE_UP: begin
          if (tick) begin
            if (cnt_one_c) begin
              floor_d = qry_floor_c;
              if (car_at_c || up_at_c || !above_c) begin
                open_c     = 1'b1;
                open_floor = qry_floor_c;
                if (above_c) open_dir = DIR_UP;
                else         open_dir = DIR_DOWN;
              end else begin
                cnt_d = CNT_W'(TRAVEL_TICKS);
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        S_MOVE_DOWN: begin
          if (tick) begin
            if (cnt_one_c) begin
              floor_d = qry_floor_c;
              if (car_at_c || dn_at_c || !below_c) begin
                open_c     = 1'b1;
                open_floor = qry_floor_c;
                if (below_c) open_dir = DIR_DOWN;
                else         open_dir = DIR_UP;
              end else begin
                cnt_d = CNT_W'(TRAVEL_TICKS);
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        S_OPEN_UP, S_OPEN_DOWN: begin
          // Presses for the call being served are absorbed, not latched
          clr_car = onehot(floor_q);
          if (dir_q == DIR_UP) clr_up = onehot(floor_q);
          else                 clr_dn = onehot(floor_q);
          if (press_c) begin
            cnt_d = CNT_W'(DOOR_TICKS);
          end else if (tick) begin
            if (cnt_one_c) begin
              state_d = S_CLOSING;
              cnt_d   = CNT_W'(CLOSE_TICKS);
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        S_CLOSING: begin
`ifdef DOOR_REOPEN_EN
          if (press_c) begin
            open_c = 1'b1;
          end else if (tick) begin
`else
          if (tick) begin
`endif
            if (cnt_one_c) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        S_EMERGENCY: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end

        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    // Door-open entry: load door time and clear the served calls at that floor
    if (open_c) begin
      dir_d   = open_dir;
      cnt_d   = CNT_W'(DOOR_TICKS);
      clr_car = onehot(open_floor);
      if (open_dir == DIR_UP) begin
        state_d = S_OPEN_UP;
        clr_up  = onehot(open_floor);
        clr_dn  = '0;
      end else begin
        state_d = S_OPEN_DOWN;
        clr_up  = '0;
        clr_dn  = onehot(open_floor);
      end
    end
  end

  // Controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      dir_q   <= DIR_UP;
      floor_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      cnt_q   <= cnt_d;
    end
  end

  assign floor     = floor_q;
  assign countdown = cnt_q;
  assign status    = state_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler (default tick counts 3/4/2).
module tb_elevator_scheduler;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       power;
  logic       emergency;
  logic [7:0] floor_btn;
  logic [7:0] up;
  logic [7:0] down;
  logic [2:0] floor;
  logic [2:0] countdown;
  logic [3:0] status;
  logic [7:0] car_req;
  logic [7:0] up_req;
  logic [7:0] down_req;

  int checks = 0;
  int errors = 0;

  elevator_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .power     (power),
    .emergency (emergency),
    .floor_btn (floor_btn),
    .up        (up),
    .down      (down),
    .floor     (floor),
    .countdown (countdown),
    .status    (status),
    .car_req   (car_req),
    .up_req    (up_req),
    .down_req  (down_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic tks(input int n);
    for (int i = 0; i < n; i++) tk();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; power = 1'b0; emergency = 1'b0;
    floor_btn = '0; up = '0; down = '0;
    #2;
    chk("rst_status", 8'(status), 8'd0);
    chk("rst_floor", 8'(floor), 8'd0);
    chk("rst_count", 8'(countdown), 8'd0);
    chk("rst_reqs", car_req | up_req | down_req, 8'h00);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("off_hold", 8'(status), 8'd0);
    power = 1'b1;
    cyc();
    chk("power_idle", 8'(status), 8'd1);

    // Car call to floor 3 from floor 0
    floor_btn = 8'h08; cyc(); floor_btn = '0;
    chk("car3_latch", car_req, 8'h08);
    chk("car3_still_idle", 8'(status), 8'd1);
    cyc();
    chk("car3_move_up", 8'(status), 8'd2);
    chk("car3_count", 8'(countdown), 8'd3);
    tks(3);
    chk("car3_floor1", 8'(floor), 8'd1);
    chk("car3_reload", 8'(countdown), 8'd3);
    tks(6);
    chk("car3_floor3", 8'(floor), 8'd3);
    chk("car3_open_down", 8'(status), 8'd5);
    chk("car3_cleared", car_req, 8'h00);
    chk("car3_door", 8'(countdown), 8'd4);
    tks(3);
    chk("car3_door_last", 8'(countdown), 8'd1);
    tk();
    chk("car3_closing", 8'(status), 8'd6);
    chk("car3_close_cnt", 8'(countdown), 8'd2);
    tks(2);
    chk("car3_idle", 8'(status), 8'd1);
    chk("car3_idle_cnt", 8'(countdown), 8'd0);

    // Return to floor 0: nothing below, so the door opens reversing to up
    floor_btn = 8'h01; cyc(); floor_btn = '0;
    cyc();
    chk("ret0_move_down", 8'(status), 8'd3);
    tks(9);
    chk("ret0_floor", 8'(floor), 8'd0);
    chk("ret0_open_up", 8'(status), 8'd4);
    tks(6);
    chk("ret0_idle", 8'(status), 8'd1);

    // Hall up at 2 plus car call at 5: intermediate stop at 2
    up = 8'h04; floor_btn = 8'h20; cyc(); up = '0; floor_btn = '0;
    chk("s2_up_latch", up_req, 8'h04);
    chk("s2_car_latch", car_req, 8'h20);
    cyc();
    tks(6);
    chk("s2_floor2", 8'(floor), 8'd2);
    chk("s2_open_up", 8'(status), 8'd4);
    chk("s2_up_cleared", up_req, 8'h00);
    chk("s2_car_kept", car_req, 8'h20);
    tks(6);
    chk("s2_idle2", 8'(status), 8'd1);
    cyc();
    chk("s2_resume_up", 8'(status), 8'd2);
    tks(9);
    chk("s2_floor5", 8'(floor), 8'd5);
    chk("s2_open_down5", 8'(status), 8'd5);
    tks(6);

    // Floor 5 to 4, arrive with nothing below -> open up, direction now up
    floor_btn = 8'h10; cyc(); floor_btn = '0;
    cyc();
    tks(3);
    chk("f4_floor", 8'(floor), 8'd4);
    chk("f4_open_up", 8'(status), 8'd4);
    tks(6);
    chk("f4_idle", 8'(status), 8'd1);

    // Down at 1 and up at 6 from floor 4: 6 is nearer, move up
    down = 8'h02; up = 8'h40; cyc(); down = '0; up = '0;
    chk("s3_up_latch", up_req, 8'h40);
    chk("s3_dn_latch", down_req, 8'h02);
    cyc();
    chk("s3_move_up", 8'(status), 8'd2);
    tks(2);
    chk("s3_cnt1", 8'(countdown), 8'd1);

    // Emergency on the arrival tick: floor held, press still latched
    emergency = 1'b1; tick = 1'b1; floor_btn = 8'h80;
    cyc();
    tick = 1'b0; floor_btn = '0;
    chk("em_status", 8'(status), 8'd7);
    chk("em_floor", 8'(floor), 8'd4);
    chk("em_count", 8'(countdown), 8'd0);
    chk("em_latch", car_req, 8'h80);
    emergency = 1'b0;
    cyc();
    chk("em_rel_idle", 8'(status), 8'd1);
    cyc();
    chk("em_restart", 8'(status), 8'd2);
    chk("em_full_cnt", 8'(countdown), 8'd3);
    tks(2);
    chk("em_not_yet", 8'(floor), 8'd4);
    tk();
    chk("em_floor5", 8'(floor), 8'd5);
    tks(3);
    chk("s3_floor6", 8'(floor), 8'd6);
    chk("s3_open_up6", 8'(status), 8'd4);
    chk("s3_up6_clr", up_req, 8'h00);
    tks(6);
    cyc();
    tks(3);
    chk("f7_floor", 8'(floor), 8'd7);
    chk("f7_open_down", 8'(status), 8'd5);
    chk("f7_car_clr", car_req, 8'h00);
    tks(6);

    // Masked hall buttons, car call to 0, pending down at 1
    up = 8'h80; down = 8'h01; floor_btn = 8'h01;
    cyc();
    up = '0; down = '0; floor_btn = '0;
    chk("mask_up7", up_req, 8'h00);
    chk("mask_dn0", down_req, 8'h02);
    chk("car0_latch", car_req, 8'h01);
    chk("f7_move_down", 8'(status), 8'd3);
    tks(18);
    chk("dn1_floor", 8'(floor), 8'd1);
    chk("dn1_open_down", 8'(status), 8'd5);
    chk("dn1_cleared", down_req, 8'h00);
    tks(2);
    floor_btn = 8'h02; cyc(); floor_btn = '0;
    chk("door_reload", 8'(countdown), 8'd4);
    chk("door_no_latch", car_req, 8'h01);
    tks(6);
    cyc();
    tks(2);

    // Press coinciding with the arrival that serves it: clear wins
    tick = 1'b1; floor_btn = 8'h01;
    cyc();
    tick = 1'b0; floor_btn = '0;
    chk("clrwin_floor", 8'(floor), 8'd0);
    chk("clrwin_open", 8'(status), 8'd4);
    chk("clrwin_car", car_req, 8'h00);
    tks(4);
    chk("cl_closing", 8'(status), 8'd6);
    floor_btn = 8'h01; cyc(); floor_btn = '0;
`ifdef DOOR_REOPEN_EN
    chk("reopen_status", 8'(status), 8'd4);
    chk("reopen_count", 8'(countdown), 8'd4);
    chk("reopen_car", car_req, 8'h00);
    tks(6);
`else
    chk("cl_latched", car_req, 8'h01);
    chk("cl_still", 8'(status), 8'd6);
    tks(2);
    chk("cl_idle", 8'(status), 8'd1);
    cyc();
    chk("cl_reopen", 8'(status), 8'd5);
    chk("cl_reopen_cnt", 8'(countdown), 8'd4);
    chk("cl_car_clr", car_req, 8'h00);
    tks(6);
`endif
    chk("pre_off_idle", 8'(status), 8'd1);

    // Power off clears requests and ignores presses
    floor_btn = 8'h10; cyc();
    chk("pre_off_latch", car_req, 8'h10);
    power = 1'b0; floor_btn = 8'h20;
    cyc();
    chk("off_status", 8'(status), 8'd0);
    chk("off_clear", car_req, 8'h00);
    cyc();
    chk("off_ignore", car_req, 8'h00);
    power = 1'b1; floor_btn = '0;
    cyc();
    chk("on_idle", 8'(status), 8'd1);

    // Asynchronous reset mid-move
    floor_btn = 8'h04; cyc(); floor_btn = '0;
    cyc();
    tks(4);
    chk("mid_floor1", 8'(floor), 8'd1);
    chk("mid_cnt", 8'(countdown), 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_floor", 8'(floor), 8'd0);
    chk("arst_status", 8'(status), 8'd0);
    chk("arst_count", 8'(countdown), 8'd0);
    chk("arst_car", car_req, 8'h00);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
